// File: rtl/hyst_threshold_detector_pkg.sv
// Shared types and helpers for the hysteresis threshold detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hyst_threshold_detector_pkg;

    // Detector states. ARM counts qualifying high samples.
    // RELEASE counts qualifying low samples.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } hyst_state_t;

    // Saturating increment. The result never exceeds maxv.
    // Callers zero-extend their operands to 32 bits and truncate the result
    // back, so one helper serves every counter width up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic [31:0] maxv);
        logic [31:0] r;
        if (v >= maxv) begin
            r = maxv;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/D_FF_enable.sv
// Generic enabled register of width WL with asynchronous active-low reset.
// Latency: 1 cycle from iD to oQ when iEN=1; holds otherwise.
// Backpressure: none.
//
// Ports: iCLK clock, iRSTn async active-low reset, iEN load enable,
//        iD data in, oQ registered data out.
module D_FF_enable #(
    parameter int WL = 1
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iEN,
    input  logic [WL-1:0] iD,
    output logic [WL-1:0] oQ
);

    logic [WL-1:0] r_q;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_q <= '0;
        end else if (iEN) begin
            r_q <= iD;
        end
    end

    assign oQ = r_q;

endmodule

// File: rtl/hyst_threshold_detector_sat_counter.sv
// Saturating up-counter with enable, synchronous clear-and-load and increment.
// Latency: 1 cycle; oQ shows the updated count the cycle after iEN.
// Backpressure: none; the counter holds when iEN=0.
//
// Ports: iCLK clock, iRSTn async active-low reset, iEN advance enable,
//        iCLR synchronous clear (loads 0, or 1 when iINC is also set),
//        iINC increment request, oQ current count.
module sat_counter
    import hyst_threshold_detector_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         iCLK,
    input  logic         iRSTn,
    input  logic         iEN,
    input  logic         iCLR,
    input  logic         iINC,
    output logic [W-1:0] oQ
);

    localparam logic [W-1:0] MAXV = '1;

    logic [W-1:0] r_q;

    // A clear with iINC set restarts the count at one. This lets a frame
    // boundary count its own first sample, and lets a new run start on the
    // sample that triggers it.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_q <= '0;
        end else if (iEN) begin
            if (iCLR) begin
                r_q <= iINC ? W'(1) : '0;
            end else if (iINC) begin
                r_q <= W'(sat_inc(32'(r_q), 32'(MAXV)));
            end
        end
    end

    assign oQ = r_q;

endmodule

// File: rtl/hyst_threshold_detector.sv
// Multi-sample hysteresis threshold detector with per-frame detection count.
// Latency: 1 cycle from a sample to oDATA/oEN; oCNT/oCNT_VLD 1 cycle after iSOF.
// Backpressure: none; iEN-qualified stream, and all state holds while iEN=0.
//
// Ports:
//   iCLK, iRSTn        clock, async active-low reset
//   iEN, iSOF          sample valid, start of frame (qualified by iEN)
//   iDATA              unsigned magnitude sample
//   iTH_HI, iTH_LO     assert threshold (>=), release threshold (<)
//   iN_ON, iN_OFF      persistence run lengths (0 behaves as 1)
//   oDATA, oEN         registered detection flag, iEN delayed one cycle
//   oCNT, oCNT_VLD     previous frame's detected-sample count, update pulse
module hyst_threshold_detector
    import hyst_threshold_detector_pkg::*;
#(
    parameter int IL = 10,
    parameter int PW = 4,
    parameter int CW = 12
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iEN,
    input  logic          iSOF,
    input  logic [IL-1:0] iDATA,
    input  logic [IL-1:0] iTH_HI,
    input  logic [IL-1:0] iTH_LO,
    input  logic [PW-1:0] iN_ON,
    input  logic [PW-1:0] iN_OFF,
    output logic          oDATA,
    output logic          oEN,
    output logic [CW-1:0] oCNT,
    output logic          oCNT_VLD
);

    hyst_state_t   r_state;
    hyst_state_t   w_state_nxt;

    logic          w_hi;
    logic          w_lo;
    logic [PW-1:0] w_n_on;
    logic [PW-1:0] w_n_off;
    logic [PW-1:0] w_run_q;
    logic [PW:0]   w_run_p1;
    logic          w_run_clr;
    logic          w_run_inc;
    logic          w_det_nxt;
    logic [CW-1:0] w_acc_q;

    logic          r_data;
    logic [CW-1:0] r_cnt;
    logic          r_cnt_vld;
    logic          r_sof_seen;

    // Each state looks at only one comparison (hi while not detecting, lo
    // while detecting), so inverted thresholds still give a defined result.
    assign w_hi = (iDATA >= iTH_HI);
    assign w_lo = (iDATA <  iTH_LO);

    assign w_n_on  = (iN_ON  == '0) ? PW'(1) : iN_ON;
    assign w_n_off = (iN_OFF == '0) ? PW'(1) : iN_OFF;

    // One extra bit so run+1 never wraps before it is compared.
    assign w_run_p1 = {1'b0, w_run_q} + (PW+1)'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_run_clr   = 1'b0;
        w_run_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hi) begin
                    if (w_n_on == PW'(1)) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_ARM;
                        w_run_clr   = 1'b1;
                        w_run_inc   = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (w_hi) begin
                    if (w_run_p1 >= {1'b0, w_n_on}) begin
                        w_state_nxt = ST_ACTIVE;
                        w_run_clr   = 1'b1;
                    end else begin
                        w_run_inc   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_run_clr   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_lo) begin
                    if (w_n_off == PW'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                        w_run_clr   = 1'b1;
                        w_run_inc   = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                if (w_lo) begin
                    if (w_run_p1 >= {1'b0, w_n_off}) begin
                        w_state_nxt = ST_IDLE;
                        w_run_clr   = 1'b1;
                    end else begin
                        w_run_inc   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                    w_run_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_run_clr   = 1'b1;
            end
        endcase
    end

    assign w_det_nxt = (w_state_nxt == ST_ACTIVE) || (w_state_nxt == ST_RELEASE);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state <= ST_IDLE;
            r_data  <= 1'b0;
        end else if (iEN) begin
            r_state <= w_state_nxt;
            r_data  <= w_det_nxt;
        end
    end

    sat_counter #(.W(PW)) u_run (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .iEN   (iEN),
        .iCLR  (w_run_clr),
        .iINC  (w_run_inc),
        .oQ    (w_run_q)
    );

    // The frame accumulator restarts on iSOF with the boundary sample's own
    // decision, so that sample is counted in the frame it opens.
    sat_counter #(.W(CW)) u_acc (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .iEN   (iEN),
        .iCLR  (iSOF),
        .iINC  (w_det_nxt),
        .oQ    (w_acc_q)
    );

    // Samples seen before the first frame boundary belong to no frame. The
    // first report after reset is therefore zero.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_cnt      <= '0;
            r_cnt_vld  <= 1'b0;
            r_sof_seen <= 1'b0;
        end else begin
            r_cnt_vld <= iEN && iSOF;
            if (iEN && iSOF) begin
                r_cnt      <= r_sof_seen ? w_acc_q : '0;
                r_sof_seen <= 1'b1;
            end
        end
    end

    D_FF_enable #(.WL(1)) u_en_dly (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .iEN   (1'b1),
        .iD    (iEN),
        .oQ    (oEN)
    );

    assign oDATA    = r_data;
    assign oCNT     = r_cnt;
    assign oCNT_VLD = r_cnt_vld;

endmodule

// File: tb/tb_hyst_threshold_detector.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the detector and frame counter.
// Two instances share stimulus; the second uses a 2-bit frame counter.
module tb_hyst_threshold_detector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sof = 1'b0;
    logic [9:0]  data = '0;
    logic [9:0]  th_hi = 10'd500;
    logic [9:0]  th_lo = 10'd300;
    logic [3:0]  n_on = 4'd3;
    logic [3:0]  n_off = 4'd2;

    logic        o_data, o_en, o_vld;
    logic [11:0] o_cnt;
    logic        o2_data, o2_en, o2_vld;
    logic [1:0]  o2_cnt;

    int n_chk = 0;
    int n_bad = 0;

    // Model state: "detecting" flag, length of the current qualifying streak,
    // frame accumulators and reported values.
    bit  m_det;
    int  m_streak;
    int  m_acc, m_acc2;
    bit  m_seen;
    int  m_cnt, m_cnt2;
    bit  m_vld, m_en;

    always #5 clk = ~clk;

    hyst_threshold_detector #(.IL(10), .PW(4), .CW(12)) dut (
        .iCLK(clk), .iRSTn(rst_n), .iEN(en), .iSOF(sof), .iDATA(data),
        .iTH_HI(th_hi), .iTH_LO(th_lo), .iN_ON(n_on), .iN_OFF(n_off),
        .oDATA(o_data), .oEN(o_en), .oCNT(o_cnt), .oCNT_VLD(o_vld)
    );

    hyst_threshold_detector #(.IL(10), .PW(4), .CW(2)) dut2 (
        .iCLK(clk), .iRSTn(rst_n), .iEN(en), .iSOF(sof), .iDATA(data),
        .iTH_HI(th_hi), .iTH_LO(th_lo), .iN_ON(n_on), .iN_OFF(n_off),
        .oDATA(o2_data), .oEN(o2_en), .oCNT(o2_cnt), .oCNT_VLD(o2_vld)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_det = 0; m_streak = 0; m_acc = 0; m_acc2 = 0; m_seen = 0;
        m_cnt = 0; m_cnt2 = 0; m_vld = 0; m_en = 0;
    endtask

    // Detection rule: while not detecting, count consecutive samples at or
    // above th_hi; N of them in a row start detection. While detecting, count
    // consecutive samples below th_lo; N of them end it. Any break restarts
    // the streak.
    task automatic model_step(input bit e, input bit s, input int d);
        int need_on, need_off;
        m_en  = e;
        m_vld = e && s;
        if (e) begin
            need_on  = (n_on  == 0) ? 1 : int'(n_on);
            need_off = (n_off == 0) ? 1 : int'(n_off);
            if (!m_det) begin
                m_streak = (d >= int'(th_hi)) ? m_streak + 1 : 0;
                if (m_streak >= need_on) begin m_det = 1; m_streak = 0; end
            end else begin
                m_streak = (d < int'(th_lo)) ? m_streak + 1 : 0;
                if (m_streak >= need_off) begin m_det = 0; m_streak = 0; end
            end
            if (s) begin
                m_cnt  = m_seen ? m_acc  : 0;
                m_cnt2 = m_seen ? m_acc2 : 0;
                m_seen = 1;
                m_acc  = int'(m_det);
                m_acc2 = int'(m_det);
            end else begin
                m_acc  = (m_acc  + int'(m_det) > 4095) ? 4095 : m_acc  + int'(m_det);
                m_acc2 = (m_acc2 + int'(m_det) > 3)    ? 3    : m_acc2 + int'(m_det);
            end
        end
    endtask

    // Present one cycle of input, then sample the outputs 1 time unit after
    // the clock edge.
    task automatic step(input bit e, input bit s, input int d);
        en = e; sof = s; data = 10'(d);
        model_step(e, s, d);
        @(posedge clk); #1;
        chk("odata", 32'(o_data), 32'(m_det));
        chk("oen",   32'(o_en),   32'(m_en));
        chk("vld",   32'(o_vld),  32'(m_vld));
        chk("cnt",   32'(o_cnt),  32'(m_cnt));
        chk("cnt2",  32'(o2_cnt), 32'(m_cnt2));
        chk("odata2", 32'(o2_data), 32'(m_det));
    endtask

    task automatic do_reset();
        en = 0; sof = 0; data = '0;
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("rst_odata", 32'(o_data), 0);
        chk("rst_oen",   32'(o_en),   0);
        chk("rst_cnt",   32'(o_cnt),  0);
        chk("rst_vld",   32'(o_vld),  0);
        chk("rst_cnt2",  32'(o2_cnt), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [6:0] exp1;
        logic [5:0] exp3;
        model_reset();
        #2;
        chk("por_odata", 32'(o_data), 0);
        chk("por_cnt",   32'(o_cnt),  0);
        @(negedge clk);
        rst_n = 1;

        // Scenario 1: basic assert/release, with a frame start on the first sample.
        th_hi = 500; th_lo = 300; n_on = 3; n_off = 2;
        exp1 = 7'b0011100;
        for (int i = 0; i < 7; i++) begin
            step(1, i == 0, (i < 4) ? 600 : 200);
            chk("s1_seq", 32'(o_data), 32'(exp1[6-i]));
            if (i == 0) chk("s1_first_cnt", 32'(o_cnt), 0);
        end

        // Scenario 2: in-band samples hold the current decision.
        repeat (3) step(1, 0, 600);
        for (int i = 0; i < 50; i++) step(1, 0, 400);
        chk("s2_hold_on", 32'(o_data), 1);
        repeat (2) step(1, 0, 200);
        for (int i = 0; i < 50; i++) step(1, 0, 400);
        chk("s2_hold_off", 32'(o_data), 0);

        // Scenario 3: a below-threshold sample breaks arming.
        exp3 = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, (i == 2) ? 450 : 600);
            chk("s3_seq", 32'(o_data), 32'(exp3[5-i]));
        end
        repeat (2) step(1, 0, 200);

        // Scenario 4: scenario 1 with idle cycles between samples.
        for (int i = 0; i < 7; i++) begin
            step(1, 0, (i < 4) ? 600 : 200);
            chk("s4_seq", 32'(o_data), 32'(exp1[6-i]));
            step(0, 0, 0);
            chk("s4_hold", 32'(o_data), 32'(exp1[6-i]));
        end

        // Scenario 5: frame count of 4, then 5 for the saturating instance.
        n_on = 1; n_off = 1;
        for (int i = 0; i < 10; i++) step(1, i == 0, (i < 4) ? 600 : 200);
        step(1, 1, 600);
        chk("s5_cnt4", 32'(o_cnt), 4);
        chk("s5_vld",  32'(o_vld), 1);
        step(1, 0, 600);
        chk("s5_vld_pulse", 32'(o_vld), 0);
        repeat (3) step(1, 0, 600);
        repeat (5) step(1, 0, 200);
        step(1, 1, 200);
        chk("s5_cnt5", 32'(o_cnt), 5);
        chk("s5_sat",  32'(o2_cnt), 3);

        // Scenario 6: reset while detecting, then N_ON=0 behaves as 1.
        n_on = 3;
        repeat (3) step(1, 0, 600);
        chk("s6_active", 32'(o_data), 1);
        do_reset();
        step(1, 0, 600);
        chk("s6_idle_after_rst", 32'(o_data), 0);
        step(1, 0, 200);
        n_on = 0;
        step(1, 0, 600);
        chk("s6_non0", 32'(o_data), 1);

        // Randomized traffic, including inverted thresholds and N changes.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                th_hi = 10'($urandom_range(0, 1023));
                th_lo = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 29) == 0) begin
                n_on  = 4'($urandom_range(0, 15));
                n_off = 4'($urandom_range(0, 15));
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 1023)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/hyst_threshold_detector.md
Name: hyst_threshold_detector

Overview:
Multi-sample hysteresis threshold detector for the STFT magnitude stream. It sits after the magnitude stage and ahead of the detection and feature logic. It asserts a detection flag after iN_ON consecutive samples reach the high threshold. It releases the flag after iN_OFF consecutive samples fall below the low threshold, and reports the per-frame count of detected samples.

Parameters:
IL, 10, magnitude and threshold width (unsigned)
PW, 4, width of the persistence run counter and of iN_ON/iN_OFF
CW, 12, width of the per-frame detection counter

Ports:
iCLK  in  1  clock
iRSTn  in  1  reset, asynchronous, active-low
iEN  in  1  sample valid; all state advances only when iEN=1
iSOF  in  1  start of frame, qualified by iEN; marks the first sample of a frame
iDATA  in  IL  unsigned magnitude sample
iTH_HI  in  IL  assert threshold; hi = (iDATA >= iTH_HI)
iTH_LO  in  IL  release threshold; lo = (iDATA < iTH_LO)
iN_ON  in  PW  consecutive hi samples needed to assert; 0 is treated as 1
iN_OFF  in  PW  consecutive lo samples needed to release; 0 is treated as 1
oDATA  out  1  registered detection flag
oEN  out  1  iEN delayed one cycle
oCNT  out  CW  detected-sample count of the previous frame, held until the next iSOF
oCNT_VLD  out  1  one-cycle pulse when oCNT updates

Behaviour:
- Reset (async, iRSTn=0): state IDLE; run counter 0; accumulator 0; oDATA, oEN, oCNT, oCNT_VLD all 0.
- Latency: oDATA and oEN reflect the sample presented in cycle t at cycle t+1. oDATA holds its value on iEN=0 cycles.
- State machine (evaluated only when iEN=1; N means max(iN_x, 1)):
  - IDLE:
    - hi and N_ON=1 -> ACTIVE.
    - hi -> ARM, run=1.
    - else stay.
  - ARM:
    - hi -> run+1; if run+1 >= N_ON -> ACTIVE, run=0.
    - not hi -> IDLE, run=0.
  - ACTIVE:
    - lo and N_OFF=1 -> IDLE.
    - lo -> RELEASE, run=1.
    - else stay.
  - RELEASE:
    - lo -> run+1; if run+1 >= N_OFF -> IDLE, run=0.
    - not lo -> ACTIVE, run=0.
- Detection output: oDATA <= 1 when the next state is ACTIVE or RELEASE, else 0.
- Run counter saturates at 2^PW-1 and never wraps.
- Hysteresis band: iTH_LO <= iDATA < iTH_HI holds the current decision.
- Misconfigured thresholds (iTH_LO > iTH_HI): ACTIVE/RELEASE evaluate only lo, IDLE/ARM evaluate only hi, so the result stays deterministic.
- Threshold and N inputs are sampled every iEN cycle; a change takes effect on the next sample and does not reset run.
- Frame counter (det_next = next oDATA value):
  - On iEN and iSOF: oCNT <= acc; oCNT_VLD <= 1 for exactly one cycle; acc <= det_next.
  - On iEN without iSOF: acc <= acc + det_next, saturating at 2^CW-1.
  - The first iSOF after reset yields oCNT=0 with oCNT_VLD=1.
- iSOF with iEN=0 is ignored.
- A reset during ACTIVE drops oDATA immediately. The partial frame count is discarded.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, ARM=2'd1, ACTIVE=2'd2, RELEASE=2'd3) and the saturating-increment helper.
- oEN delay: reuse the existing D_FF_enable (WL=1, iEN=1'b1).
- One natural sub-module: sat_counter (parametrised width, enable, sync clear, saturating increment). It is instantiated once for run and once for acc.

Test Plan:
1. TH_HI=500, TH_LO=300, N_ON=3, N_OFF=2, iEN=1; iDATA 600,600,600,600,200,200,200 -> oDATA 0,0,1,1,1,0,0, each one cycle after its sample.
2. Hysteresis with the same settings: from ACTIVE, 50 samples of 400 -> oDATA stays 1; from IDLE, 50 samples of 400 -> oDATA stays 0.
3. Broken arming, N_ON=3: iDATA 600,600,450,600,600,600 -> oDATA 0,0,0,0,0,1.
4. iEN gaps: scenario 1 with iEN=0 between samples and iDATA=0 during those cycles -> identical oDATA sequence on oEN cycles; oDATA holds while oEN=0; oEN = iEN delayed 1.
5. Frame count: iSOF, then 10 samples giving 4 detected, then iSOF -> oCNT=4 with a single-cycle oCNT_VLD. CW=2 with 5 detected -> oCNT=3 (saturated).
6. Reset and edge cases:
   - Assert iRSTn=0 mid-ACTIVE, between clock edges -> oDATA, oEN, oCNT, oCNT_VLD go 0 immediately; after release, state IDLE.
   - N_ON=0 -> one 600 sample asserts oDATA on the next cycle.
